// File: rtl/jpeg_bitstream_writer.sv
// jpeg_bitstream_writer: packs MSB-first variable-length codes into bytes,
// stuffs 0x00 after every data 0xFF and pads the last partial byte with 1s
// on flush. Define JPEG_BSW_EOI_EN to append an unstuffed 0xFF 0xD9 EOI
// marker after the flushed data.
module jpeg_bitstream_writer #(
  parameter int unsigned MAX_LEN = 27,
  parameter int unsigned ACC_W   = MAX_LEN + 15
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic [MAX_LEN-1:0] code_in,
  input  logic [5:0]         code_len,
  input  logic               code_valid,
  output logic               code_ready,
  input  logic               flush,
  output logic [7:0]         byte_out,
  output logic               byte_valid,
  input  logic               byte_ready,
  output logic               flush_done,
  output logic [31:0]        byte_count
);

  localparam int unsigned CNT_W = $clog2(ACC_W + 1);
  localparam int unsigned CAP   = ACC_W - MAX_LEN;

`ifdef JPEG_BSW_EOI_EN
  typedef enum logic [2:0] {S_RUN, S_STUFF, S_FLUSH, S_MARK_FF, S_MARK_D9} state_e;
`else
  typedef enum logic [1:0] {S_RUN, S_STUFF, S_FLUSH} state_e;
`endif

  state_e             state_q, state_d;
  logic               ret_flush_q, ret_flush_d;
  logic [ACC_W-1:0]   acc_q, acc_d;
  logic [CNT_W-1:0]   bit_count_q, bit_count_d;
  logic [7:0]         byte_out_q, byte_out_d;
  logic               byte_valid_q, byte_valid_d;
  logic               flush_done_q, flush_done_d;
  logic [31:0]        byte_count_q, byte_count_d;
  logic               code_ready_q, code_ready_d;
`ifdef JPEG_BSW_EOI_EN
  logic               mark_sent_q, mark_sent_d;
`endif

  logic [5:0]         len_sat, len_acc;
  logic               accept, out_free, ld_en, empty_c;
  logic [7:0]         ld_byte;
  logic [ACC_W-1:0]   mask, code_m, acc_m;
  logic [CNT_W-1:0]   shamt, cnt_m;

  // State and datapath registers
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= S_RUN;
      ret_flush_q  <= 1'b0;
      acc_q        <= '0;
      bit_count_q  <= '0;
      byte_out_q   <= 8'h00;
      byte_valid_q <= 1'b0;
      flush_done_q <= 1'b0;
      byte_count_q <= 32'd0;
      code_ready_q <= 1'b1;
`ifdef JPEG_BSW_EOI_EN
      mark_sent_q  <= 1'b0;
`endif
    end else begin
      state_q      <= state_d;
      ret_flush_q  <= ret_flush_d;
      acc_q        <= acc_d;
      bit_count_q  <= bit_count_d;
      byte_out_q   <= byte_out_d;
      byte_valid_q <= byte_valid_d;
      flush_done_q <= flush_done_d;
      byte_count_q <= byte_count_d;
      code_ready_q <= code_ready_d;
`ifdef JPEG_BSW_EOI_EN
      mark_sent_q  <= mark_sent_d;
`endif
    end
  end

  // Merge the accepted code below the valid bits and pick the byte to load
  always_comb begin
    len_sat     = (code_len > 6'(MAX_LEN)) ? 6'(MAX_LEN) : code_len;
    accept      = (state_q == S_RUN) && code_ready_q && code_valid;
    len_acc     = accept ? len_sat : 6'd0;
    mask        = (ACC_W'(1) << len_acc) - ACC_W'(1);
    code_m      = ACC_W'(code_in) & mask;
    shamt       = CNT_W'(ACC_W) - bit_count_q - CNT_W'(len_acc);
    acc_m       = acc_q | (code_m << shamt);
    cnt_m       = bit_count_q + CNT_W'(len_acc);
    out_free    = !byte_valid_q || byte_ready;
    ld_en       = 1'b0;
    ld_byte     = 8'h00;
    empty_c     = 1'b0;
    acc_d       = acc_q;
    bit_count_d = bit_count_q;
    unique case (state_q)
      S_RUN: begin
        acc_d       = acc_m;
        bit_count_d = cnt_m;
        if (out_free && (cnt_m >= CNT_W'(8))) begin
          ld_en       = 1'b1;
          ld_byte     = acc_m[ACC_W-1 -: 8];
          acc_d       = acc_m << 8;
          bit_count_d = cnt_m - CNT_W'(8);
        end else if (out_free && (cnt_m == '0)) begin
          empty_c = 1'b1;
        end
      end
      S_STUFF: begin
        ld_en   = out_free;
        ld_byte = 8'h00;
      end
      S_FLUSH: begin
        if (out_free) begin
          if (bit_count_q >= CNT_W'(8)) begin
            ld_en       = 1'b1;
            ld_byte     = acc_q[ACC_W-1 -: 8];
            acc_d       = acc_q << 8;
            bit_count_d = bit_count_q - CNT_W'(8);
          end else if (bit_count_q != '0) begin
            // residual bits sit at the top; fill the rest of the byte with 1s
            ld_en       = 1'b1;
            ld_byte     = acc_q[ACC_W-1 -: 8] | (8'hFF >> bit_count_q[2:0]);
            acc_d       = '0;
            bit_count_d = '0;
          end else begin
            empty_c = 1'b1;
          end
        end
      end
`ifdef JPEG_BSW_EOI_EN
      S_MARK_FF: begin
        ld_en   = out_free;
        ld_byte = 8'hFF;
      end
      S_MARK_D9: begin
        ld_en   = out_free && !mark_sent_q;
        ld_byte = 8'hD9;
        empty_c = out_free && mark_sent_q;
      end
`endif
      default: ;
    endcase
  end

  // Next-state logic
  always_comb begin
    state_d     = state_q;
    ret_flush_d = ret_flush_q;
`ifdef JPEG_BSW_EOI_EN
    mark_sent_d = mark_sent_q;
`endif
    unique case (state_q)
      S_RUN: begin
        if (ld_en && (ld_byte == 8'hFF)) begin
          state_d     = S_STUFF;
          ret_flush_d = flush;
        end else if (flush) begin
`ifdef JPEG_BSW_EOI_EN
          state_d = empty_c ? S_MARK_FF : S_FLUSH;
`else
          state_d = empty_c ? S_RUN : S_FLUSH;
`endif
        end
      end
      S_STUFF: begin
        if (ld_en) state_d = ret_flush_q ? S_FLUSH : S_RUN;
      end
      S_FLUSH: begin
        if (ld_en && (ld_byte == 8'hFF)) begin
          state_d     = S_STUFF;
          ret_flush_d = 1'b1;
        end else if (empty_c) begin
`ifdef JPEG_BSW_EOI_EN
          state_d = S_MARK_FF;
`else
          state_d = S_RUN;
`endif
        end
      end
`ifdef JPEG_BSW_EOI_EN
      S_MARK_FF: begin
        if (ld_en) state_d = S_MARK_D9;
      end
      S_MARK_D9: begin
        if (ld_en) begin
          mark_sent_d = 1'b1;
        end else if (empty_c) begin
          mark_sent_d = 1'b0;
          state_d     = S_RUN;
        end
      end
`endif
      default: state_d = S_RUN;
    endcase
  end

  // Output register next values
  always_comb begin
    byte_out_d   = ld_en ? ld_byte : byte_out_q;
    byte_valid_d = ld_en || (byte_valid_q && !byte_ready);
    byte_count_d = byte_count_q + ((byte_valid_q && byte_ready) ? 32'd1 : 32'd0);
    flush_done_d = 1'b0;
`ifdef JPEG_BSW_EOI_EN
    if ((state_q == S_MARK_D9) && empty_c) flush_done_d = 1'b1;
`else
    if ((state_q == S_RUN) && flush && empty_c && !ld_en) flush_done_d = 1'b1;
    if ((state_q == S_FLUSH) && empty_c) flush_done_d = 1'b1;
`endif
    code_ready_d = (state_d == S_RUN) && (bit_count_d <= CNT_W'(CAP));
  end

  assign code_ready = code_ready_q;
  assign byte_out   = byte_out_q;
  assign byte_valid = byte_valid_q;
  assign flush_done = flush_done_q;
  assign byte_count = byte_count_q;

endmodule

// File: tb/tb_jpeg_bitstream_writer.sv
// Self-checking bench for jpeg_bitstream_writer: bit-level reference model
// feeds an expected-byte queue that the output monitor drains.
module tb_jpeg_bitstream_writer;

  localparam int unsigned MAX_LEN = 27;

  logic               clk = 1'b0;
  logic               rst_n;
  logic [MAX_LEN-1:0] code_in;
  logic [5:0]         code_len;
  logic               code_valid;
  logic               code_ready;
  logic               flush;
  logic [7:0]         byte_out;
  logic               byte_valid;
  logic               byte_ready;
  logic               flush_done;
  logic [31:0]        byte_count;

  int         errs = 0;
  int         checks = 0;
  int         xfer_n = 0;
  logic [7:0] exp_q[$];
  bit         mq[$];
  bit         rnd_rdy = 1'b0;
  bit         rdy_val = 1'b1;
  bit         prev_stall = 1'b0;
  logic [7:0] prev_byte = 8'h00;
  bit         prev_fd = 1'b0;

  jpeg_bitstream_writer #(.MAX_LEN(MAX_LEN)) dut (
    .clk(clk), .rst_n(rst_n), .code_in(code_in), .code_len(code_len),
    .code_valid(code_valid), .code_ready(code_ready), .flush(flush),
    .byte_out(byte_out), .byte_valid(byte_valid), .byte_ready(byte_ready),
    .flush_done(flush_done), .byte_count(byte_count)
  );

  always #5 clk = ~clk;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errs++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic emit(input logic [7:0] b, input bit stuff);
    exp_q.push_back(b);
    if (stuff && b == 8'hFF) exp_q.push_back(8'h00);
  endtask

  task automatic model_push(input logic [31:0] c, input int l);
    int ls;
    logic [7:0] b;
    ls = (l > MAX_LEN) ? MAX_LEN : l;
    for (int i = ls - 1; i >= 0; i--) mq.push_back(c[i]);
    while (mq.size() >= 8) begin
      b = 8'h00;
      for (int k = 0; k < 8; k++) b = {b[6:0], mq.pop_front()};
      emit(b, 1'b1);
    end
  endtask

  task automatic model_flush();
    logic [7:0] b;
    if (mq.size() > 0) begin
      while (mq.size() < 8) mq.push_back(1'b1);
      b = 8'h00;
      for (int k = 0; k < 8; k++) b = {b[6:0], mq.pop_front()};
      emit(b, 1'b1);
    end
`ifdef JPEG_BSW_EOI_EN
    emit(8'hFF, 1'b0);
    emit(8'hD9, 1'b0);
`endif
  endtask

  task automatic next_cycle();
    @(posedge clk);
    #1;
  endtask

  task automatic push(input logic [31:0] c, input int l);
    bit ok;
    int n;
    code_in    = c[MAX_LEN-1:0];
    code_len   = 6'(l);
    code_valid = 1'b1;
    ok = 1'b0;
    n  = 0;
    while (!ok && n < 500) begin
      @(negedge clk);
      ok = code_ready;
      next_cycle();
      n++;
    end
    code_valid = 1'b0;
    if (ok) model_push(c, l);
    else check_eq("push_timeout", 32'(ok), 32'd1);
  endtask

  task automatic drain();
    int n;
    n = 0;
    while (exp_q.size() != 0 && n < 500) begin
      @(negedge clk);
      n++;
    end
    check_eq("drain", 32'(exp_q.size()), 32'd0);
    next_cycle();
  endtask

  task automatic do_flush(input bit empty, output int n);
    bit seen;
    flush = 1'b1;
    next_cycle();
    flush = 1'b0;
    model_flush();
    seen = 1'b0;
    n = 0;
    while (!seen && n < 500) begin
      @(negedge clk);
      n++;
      if (n == 1 && !empty) check_eq("cr_in_flush", 32'(code_ready), 32'd0);
      if (flush_done) seen = 1'b1;
    end
    check_eq("flush_done_seen", 32'(seen), 32'd1);
    check_eq("flush_drained", 32'(exp_q.size()), 32'd0);
    check_eq("cr_after_flush", 32'(code_ready), 32'd1);
    next_cycle();
  endtask

  // Sink-side ready driver: fixed level or random backpressure
  initial begin
    byte_ready = 1'b1;
    forever begin
      @(posedge clk);
      #1;
      byte_ready = rnd_rdy ? ($urandom_range(0, 3) != 0) : rdy_val;
    end
  end

  // Output monitor: scoreboard compare, hold-stable and pulse-width checks
  always @(negedge clk) begin
    if (!rst_n) begin
      prev_stall = 1'b0;
      prev_fd    = 1'b0;
    end else begin
      if (prev_stall) begin
        check_eq("hold_valid", 32'(byte_valid), 32'd1);
        check_eq("hold_byte", 32'(byte_out), 32'(prev_byte));
      end
      if (byte_valid && byte_ready) begin
        xfer_n++;
        if (exp_q.size() == 0) check_eq("extra_byte", {24'd0, byte_out}, 32'hFFFF_FFFF);
        else check_eq("byte", 32'(byte_out), 32'(exp_q.pop_front()));
      end
      if (flush_done) check_eq("fd_width", 32'(prev_fd), 32'd0);
      prev_stall = byte_valid && !byte_ready;
      prev_byte  = byte_out;
      prev_fd    = flush_done;
    end
  end

  initial begin
    int n;
    int acc_n;
    rst_n = 1'b0; code_in = '0; code_len = '0; code_valid = 1'b0; flush = 1'b0;
    repeat (2) next_cycle();
    check_eq("rst_valid", 32'(byte_valid), 32'd0);
    check_eq("rst_ready", 32'(code_ready), 32'd1);
    check_eq("rst_count", byte_count, 32'd0);
    check_eq("rst_byte", 32'(byte_out), 32'd0);
    rst_n = 1'b1;
    next_cycle();

    // single byte, latency
    push(32'hAB, 8);
    @(negedge clk);
    check_eq("lat_valid", 32'(byte_valid), 32'd1);
    check_eq("lat_byte", 32'(byte_out), 32'hAB);
    drain();
    check_eq("count_ab", byte_count, 32'd1);

    // stuffing after 0xFF
    push(32'hFF, 8);
    @(negedge clk);
    check_eq("stuff_ff", 32'(byte_out), 32'hFF);
    check_eq("cr_stuff", 32'(code_ready), 32'd0);
    @(negedge clk);
    check_eq("stuff_00", 32'(byte_out), 32'h00);
    check_eq("stuff_valid", 32'(byte_valid), 32'd1);
    drain();
    check_eq("count_stuff", byte_count, 32'd3);

    // split codes and padded flush
    push(32'h1, 4);
    push(32'h234, 12);
    push(32'h5, 3);
    do_flush(1'b0, n);

    // no-op and saturated lengths, with junk above code_len
    push(32'hFFFF_FFFF, 0);
    push(32'h5A5_A5A5, 40);
    push(32'hFFFF_FFF3, 5);
    drain();

    // backpressure while pushing every cycle
    rdy_val = 1'b0;
    repeat (2) next_cycle();
    acc_n = 0;
    for (int i = 0; i < 10; i++) begin
      code_in = 27'(8'h20 + acc_n); code_len = 6'd8; code_valid = 1'b1;
      @(negedge clk);
      if (code_ready) begin
        model_push(32'(8'h20 + acc_n), 8);
        acc_n++;
      end
      next_cycle();
    end
    code_valid = 1'b0;
    @(negedge clk);
    check_eq("bp_accepts", 32'(acc_n), 32'd3);
    check_eq("bp_cr_low", 32'(code_ready), 32'd0);
    rdy_val = 1'b1;
    drain();

    // padded 0xFF gets stuffed, then empty flush
    push(32'h7F, 7);
    do_flush(1'b0, n);
    n = 0;
    do_flush(1'b1, n);
`ifndef JPEG_BSW_EOI_EN
    check_eq("empty_flush_lat", 32'(n), 32'd1);
`endif

    // random stream with random sink backpressure
    rnd_rdy = 1'b1;
    for (int i = 0; i < 60; i++) push($urandom, $urandom_range(0, 30));
    drain();
    do_flush(1'b0, n);
    rnd_rdy = 1'b0;
    rdy_val = 1'b1;
    repeat (2) next_cycle();
    check_eq("byte_count", byte_count, 32'(xfer_n));

    // reset mid-stream with a stalled byte
    rdy_val = 1'b0;
    repeat (2) next_cycle();
    push(32'h55, 8);
    push(32'h66, 8);
    @(negedge clk);
    check_eq("pre_rst_valid", 32'(byte_valid), 32'd1);
    rst_n = 1'b0;
    #2;
    check_eq("mid_rst_valid", 32'(byte_valid), 32'd0);
    check_eq("mid_rst_byte", 32'(byte_out), 32'd0);
    check_eq("mid_rst_ready", 32'(code_ready), 32'd1);
    check_eq("mid_rst_fd", 32'(flush_done), 32'd0);
    check_eq("mid_rst_count", byte_count, 32'd0);
    exp_q.delete();
    mq.delete();
    xfer_n = 0;
    next_cycle();
    rst_n = 1'b1;
    rdy_val = 1'b1;
    repeat (2) next_cycle();
    push(32'hC3, 8);
    @(negedge clk);
    check_eq("post_rst_byte", 32'(byte_out), 32'hC3);
    drain();
    check_eq("post_rst_count", byte_count, 32'd1);

    $display("Result: errors=%0d of %0d checks", errs, checks);
    $finish;
  end

endmodule
